pipeline_alu: RTL

Parametrised successor to the fixed 5-bit pipelined adder. Computes combine(((a+b)-(c+d)), e, op) over a 3-stage pipeline with valid/ready flow control and back-pressure. Adds a borrow flag and a selectable final operation. Sits between an operand source and a result consumer in the datapath.

---
 rtl/pipeline_alu_pkg.sv | 13 +
 rtl/pipe_slice.sv | 32 +++
 rtl/pipeline_alu.sv | 107 ++++++++++
 3 files changed

// File: rtl/pipeline_alu_pkg.sv
// Shared definitions for pipeline_alu: final-combine op encoding and default width.
package pipeline_alu_pkg;

  localparam int unsigned DEFAULT_WIDTH = 5;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_PASS = 2'b11
  } alu_op_e;

endpackage

// File: rtl/pipe_slice.sv
// One pipeline stage: payload register plus valid bit, loading when empty or draining.
module pipe_slice #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_ready_c
);

  logic         r_valid;
  logic [W-1:0] r_data;

  assign o_ready_c = !r_valid || i_ready;
  assign o_valid   = r_valid;
  assign o_data    = r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_ready_c) begin
      r_valid <= i_valid;
      if (i_valid) r_data <= i_data;
    end
  end

endmodule

// File: rtl/pipeline_alu.sv
// 3-stage valid/ready ALU: s = combine((a+b)-(c+d), e, op) with borrow flag.
// Define PIPELINE_ALU_SAT_EN to clamp the difference to [0, 2^WIDTH-1] instead of wrapping.
module pipeline_alu
  import pipeline_alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             borrow
);

  localparam int unsigned PW  = WIDTH + 1;
  localparam int unsigned DW  = WIDTH + 2;
  localparam int unsigned S1W = 2 * PW + WIDTH + 2;
  localparam int unsigned S2W = DW + 1 + WIDTH + 2;
  localparam int unsigned S3W = WIDTH + 1;

  logic [S1W-1:0]   w_s1_d, w_s1_q;
  logic [S2W-1:0]   w_s2_d, w_s2_q;
  logic [S3W-1:0]   w_s3_d, w_s3_q;
  logic             w_v1, w_v2, w_rdy2, w_rdy3;

  logic [PW-1:0]    w_p, w_q, w_p1, w_q1;
  logic [WIDTH-1:0] w_e1, w_e2;
  logic [1:0]       w_op1, w_op2;
  logic [DW-1:0]    w_diff_raw, w_diff, w_diff2;
  logic             w_borrow, w_borrow2;
  logic [WIDTH-1:0] w_trunc, w_res;
  logic             w_unused;

  // Stage 1: lossless partial sums
  assign w_p    = PW'(a) + PW'(b);
  assign w_q    = PW'(c) + PW'(d);
  assign w_s1_d = {w_p, w_q, e, op};

  pipe_slice #(.W(S1W)) u_s1 (
    .clk(clk), .rst_n(reset),
    .i_valid(in_valid), .i_data(w_s1_d), .i_ready(w_rdy2),
    .o_valid(w_v1), .o_data(w_s1_q), .o_ready_c(in_ready)
  );

  assign {w_p1, w_q1, w_e1, w_op1} = w_s1_q;

  // Stage 2: signed difference and borrow
  assign w_diff_raw = DW'(w_p1) - DW'(w_q1);
  assign w_borrow   = (w_p1 < w_q1);

`ifdef PIPELINE_ALU_SAT_EN
  localparam logic [DW-1:0] MAXV = {2'b00, {WIDTH{1'b1}}};

  always_comb begin
    w_diff = w_diff_raw;
    if (w_borrow)                w_diff = '0;
    else if (w_diff_raw > MAXV)  w_diff = MAXV;
  end
`else
  assign w_diff = w_diff_raw;
`endif

  assign w_s2_d = {w_diff, w_borrow, w_e1, w_op1};

  pipe_slice #(.W(S2W)) u_s2 (
    .clk(clk), .rst_n(reset),
    .i_valid(w_v1), .i_data(w_s2_d), .i_ready(w_rdy3),
    .o_valid(w_v2), .o_data(w_s2_q), .o_ready_c(w_rdy2)
  );

  assign {w_diff2, w_borrow2, w_e2, w_op2} = w_s2_q;

  // Stage 3: truncate to WIDTH and apply the final combine
  assign w_trunc  = w_diff2[WIDTH-1:0];
  assign w_unused = ^w_diff2[DW-1:WIDTH];

  always_comb begin
    w_res = w_trunc;
    case (alu_op_e'(w_op2))
      OP_AND:  w_res = w_trunc & w_e2;
      OP_OR:   w_res = w_trunc | w_e2;
      OP_XOR:  w_res = w_trunc ^ w_e2;
      OP_PASS: w_res = w_trunc;
      default: w_res = w_trunc;
    endcase
  end

  assign w_s3_d = {w_borrow2, w_res};

  pipe_slice #(.W(S3W)) u_s3 (
    .clk(clk), .rst_n(reset),
    .i_valid(w_v2), .i_data(w_s3_d), .i_ready(out_ready),
    .o_valid(out_valid), .o_data(w_s3_q), .o_ready_c(w_rdy3)
  );

  assign {borrow, s} = w_s3_q;

endmodule
